edge_detector_stream_tx: RTL and testbench
==========================================

# edge_detector_stream_tx

Avalon-ST source stage at the output of the edge-detection datapath. It accepts processed pixels one at a time over a valid/ready push interface, buffers them in a small FIFO, and transmits each frame of (IMG_X_SIZE-2)*(IMG_Y_SIZE-2) pixels as one Avalon-ST packet, framed with startofpacket/endofpacket. It is the transmitting counterpart of the pixel-loading side of the detector, and pushes backpressure from the sink back to the detector controller.

## Interface
Parameters:
- IMG_X_SIZE, 100, input image width; output frame width is IMG_X_SIZE-2
- IMG_Y_SIZE, 100, input image height; output frame height is IMG_Y_SIZE-2
- FIFO_DEPTH, 4, buffer entries; power of two, ≥2

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- clear_i  in  1  synchronous flush: empty FIFO, zero counters, state IDLE
- Pixel_i  in  8  processed pixel from datapath
- pixelValid_i  in  1  Pixel_i valid
- pixelReady_o  out  1  block accepts Pixel_i this cycle
- Data_o  out  8  Avalon-ST data
- valid_o  out  1  Avalon-ST valid
- ready_i  in  1  Avalon-ST ready (readyLatency 0)
- startofpacket_o  out  1  first beat of frame
- endofpacket_o  out  1  last beat of frame
- frameDone_o  out  1  one-cycle pulse after last beat accepted

## Operation
- N = (IMG_X_SIZE-2)*(IMG_Y_SIZE-2); counter width CNT_BITS = $clog2(N+1). Default N = 9604.
- Push = pixelValid_i & pixelReady_o. Pop = valid_o & ready_i.
- pixelReady_o = (state ≠ DRAIN) & !full. No write-through when full, even if a pop occurs in the same cycle.
- valid_o = !empty; Data_o = FIFO head. Data_o is don't-care when valid_o = 0.
- inCnt counts pushes in the frame; outCnt counts pops in the frame.
- startofpacket_o = valid_o & (outCnt == 0); endofpacket_o = valid_o & (outCnt == N-1).
- FSM:
  - IDLE: inCnt = 0. First push → FILL; if N == 1, first push → DRAIN.
  - FILL: push that makes inCnt == N → DRAIN.
  - DRAIN: no pushes accepted. Pop with outCnt == N-1 → IDLE; on that transition inCnt and outCnt both reset to 0.
- frameDone_o is registered: it is high in the cycle after the final pop.
- Simultaneous push and pop while not full: both take effect and occupancy is unchanged.
- clear_i overrides every other input in the same cycle. It drops any partial frame with no EOP.
- The Avalon rule that Data_o/SOP/EOP hold while valid_o & !ready_i is met by construction, because the FIFO head does not change without a pop.

## Timing
- Reset values: valid_o=0, startofpacket_o=0, endofpacket_o=0, frameDone_o=0, state IDLE, FIFO empty, counters 0.
- pixelReady_o reads 1 during and immediately after reset, since it is combinational from the IDLE/empty reset state.
- Latency: a pixel pushed into an empty FIFO at edge k drives valid_o at edge k+1.
- Throughput: 1 pixel/cycle sustained when ready_i is held high.
- Asserting rst_i mid-frame returns all state to reset values immediately.
- Pixels accepted before a reset or clear are lost and are never transmitted.

## Structure
- Shared package edge_detector_pkg holds:
  - state enum {IDLE, FILL, DRAIN}
  - frame-size constant function FRAME_PIXELS(x,y) = (x-2)*(y-2)
- Sub-module SyncFifo, parameters WIDTH=8 and DEPTH:
  - push/pop, full/empty, synchronous clear, async reset
  - pointers carry one extra wrap bit
- Top level holds the FSM, inCnt/outCnt, framing logic and the frameDone register.

## Test plan
Default parameters for these scenarios: IMG_X_SIZE=IMG_Y_SIZE=4 (N=4), FIFO_DEPTH=2.
- Reset, then idle → valid_o=0, pixelReady_o=1, frameDone_o=0.
- Push 10,20,30,40 back-to-back, ready_i=1 → Data_o 10,20,30,40 on consecutive cycles starting 1 cycle after the first push; SOP with 10; EOP with 40; frameDone_o pulses 1 cycle after the 40 beat.
- ready_i=0, push 3 pixels → pixelReady_o falls after 2 pushes; valid_o=1 with Data_o held at the first pixel and SOP held; release ready_i → all 3 delivered in order.
- Push 5 pixels with ready_i=0 for 3 cycles after the 4th push → 5th pixel refused (pixelReady_o=0 in DRAIN) until frameDone_o; the 5th pixel then becomes SOP of frame 2.
- clear_i after 2 pushes → valid_o=0 next cycle; next 4 pushes form a clean packet with SOP on the first of them.
- rst_i asserted mid-frame while valid_o=1 → valid_o drops with no clock edge; the following frame restarts with SOP.

Source files
------------

// File: rtl/edge_detector_stream_tx_pkg.sv
// Shared types and helpers for the edge-detector output stream.
package edge_detector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int FRAME_PIXELS(input int x, input int y);
        return (x - 2) * (y - 2);
    endfunction

endpackage

// File: rtl/edge_detector_stream_tx_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit.
module SyncFifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i && !full_o)
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop_i && !empty_o)
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clear_i && push_i && !full_o)
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/edge_detector_stream_tx.sv
// Avalon-ST source: buffers processed pixels and frames each image as a packet.
import edge_detector_pkg::*;

module edge_detector_stream_tx #(
    parameter int IMG_X_SIZE = 100,
    parameter int IMG_Y_SIZE = 100,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic [7:0] Pixel_i,
    input  logic       pixelValid_i,
    output logic       pixelReady_o,
    output logic [7:0] Data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       startofpacket_o,
    output logic       endofpacket_o,
    output logic       frameDone_o
);

    localparam int N        = FRAME_PIXELS(IMG_X_SIZE, IMG_Y_SIZE);
    localparam int CNT_BITS = $clog2(N + 1);
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(N - 1);

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_BITS-1:0] out_cnt_q, out_cnt_d;
    logic                done_q, done_d;

    logic full, empty, push, pop, last_pop;

    assign pixelReady_o    = (state_q != DRAIN) && !full;
    assign valid_o         = !empty;
    assign push            = pixelValid_i && pixelReady_o;
    assign pop             = valid_o && ready_i;
    assign last_pop        = pop && (out_cnt_q == LAST);
    assign startofpacket_o = valid_o && (out_cnt_q == '0);
    assign endofpacket_o   = valid_o && (out_cnt_q == LAST);
    assign frameDone_o     = done_q;

    SyncFifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (push),
        .wdata_i (Pixel_i),
        .pop_i   (pop),
        .rdata_o (Data_o),
        .full_o  (full),
        .empty_o (empty)
    );

    // Final pop (DRAIN only) and pushes (never DRAIN) are mutually exclusive.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        done_d    = 1'b0;
        if (clear_i) begin
            state_d   = IDLE;
            in_cnt_d  = '0;
            out_cnt_d = '0;
        end else begin
            if (pop) begin
                if (last_pop) begin
                    state_d   = IDLE;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    done_d    = 1'b1;
                end else begin
                    out_cnt_d = out_cnt_q + CNT_BITS'(1);
                end
            end
            if (push) begin
                in_cnt_d = in_cnt_q + CNT_BITS'(1);
                state_d  = (in_cnt_q == LAST) ? DRAIN : FILL;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_edge_detector_stream_tx.sv
// Randomized and directed bench for edge_detector_stream_tx against a queue model.
module tb_edge_detector_stream_tx;

    localparam int X = 4;
    localparam int Y = 4;
    localparam int D = 2;
    localparam int N = (X - 2) * (Y - 2);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] pix = 8'h00;
    logic       pv  = 1'b0;
    logic       rdy = 1'b0;
    logic       prdy, vld, sop, eop, fdone;
    logic [7:0] dat;

    edge_detector_stream_tx #(
        .IMG_X_SIZE (X),
        .IMG_Y_SIZE (Y),
        .FIFO_DEPTH (D)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .clear_i         (clr),
        .Pixel_i         (pix),
        .pixelValid_i    (pv),
        .pixelReady_o    (prdy),
        .Data_o          (dat),
        .valid_o         (vld),
        .ready_i         (rdy),
        .startofpacket_o (sop),
        .endofpacket_o   (eop),
        .frameDone_o     (fdone)
    );

    always #5 clk = ~clk;

    byte unsigned q[$];
    int  acc, dlv, frames;
    bit  done_e;
    int  n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        acc    = 0;
        dlv    = 0;
        done_e = 1'b0;
    endtask

    task automatic check_outs();
        bit has;
        has = (q.size() > 0);
        chk("pixelReady", prdy, (acc < N) && (q.size() < D));
        chk("valid", vld, has);
        if (has)
            chk("data", dat, q[0]);
        chk("sop", sop, has && (dlv == 0));
        chk("eop", eop, has && (dlv == N - 1));
        chk("frameDone", fdone, done_e);
    endtask

    // One clock: model predicts handshakes from current inputs, then outputs are checked.
    task automatic step(output bit pushed);
        bit er, pu, po, last;
        er   = (acc < N) && (q.size() < D);
        pu   = pv && er && !clr;
        po   = (q.size() > 0) && rdy && !clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            last = po && (dlv == N - 1);
            if (po) begin
                void'(q.pop_front());
                dlv++;
            end
            if (pu) begin
                q.push_back(pix);
                acc++;
            end
            if (last) begin
                acc = 0;
                dlv = 0;
                frames++;
            end
            done_e = last;
        end
        pushed = pu;
        #1;
        check_outs();
    endtask

    task automatic idle(input int n);
        bit ok;
        for (int i = 0; i < n; i++)
            step(ok);
    endtask

    task automatic send(input logic [7:0] p);
        bit ok;
        ok  = 1'b0;
        pix = p;
        pv  = 1'b1;
        for (int i = 0; i < 50 && !ok; i++)
            step(ok);
        if (!ok)
            chk("send_timeout", 32'd0, 32'd1);
        pv = 1'b0;
    endtask

    task automatic flush();
        clr = 1'b1;
        pv  = 1'b0;
        idle(1);
        clr = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", vld, 1'b0);
        chk("rst_ready", prdy, 1'b1);
        chk("rst_sop", sop, 1'b0);
        chk("rst_eop", eop, 1'b0);
        chk("rst_done", fdone, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outs();
    endtask

    initial begin
        bit ok;
        n_chk  = 0;
        n_fail = 0;
        frames = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        rst = 1'b0;
        idle(2);

        // Back-to-back frame with sink always ready.
        rdy = 1'b1;
        send(8'd10);
        chk("s2_first", dat, 8'd10);
        chk("s2_sop", sop, 1'b1);
        send(8'd20);
        send(8'd30);
        send(8'd40);
        chk("s2_eop", eop, 1'b1);
        idle(1);
        chk("s2_done", fdone, 1'b1);
        idle(2);

        // Backpressure with sink stalled.
        rdy = 1'b0;
        send(8'd1);
        send(8'd2);
        chk("s3_full", prdy, 1'b0);
        pix = 8'd3;
        pv  = 1'b1;
        idle(3);
        chk("s3_hold", dat, 8'd1);
        rdy = 1'b1;
        send(8'd3);
        idle(3);
        flush();

        // Fifth pixel waits out DRAIN and opens frame 2.
        rdy = 1'b1;
        for (int i = 0; i < 4; i++)
            send(8'(8'h50 + i));
        rdy = 1'b0;
        pix = 8'h55;
        pv  = 1'b1;
        idle(3);
        rdy = 1'b1;
        send(8'h55);
        chk("s4_sop2", sop && (dat == 8'h55), 1'b1);
        idle(3);
        flush();

        // Clear drops a partial frame.
        rdy = 1'b0;
        send(8'h11);
        send(8'h12);
        flush();
        chk("s5_clr_valid", vld, 1'b0);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++)
            send(8'(8'h21 + i));
        idle(3);

        // Async reset mid-frame.
        rdy = 1'b0;
        send(8'h33);
        chk("s6_valid_before", vld, 1'b1);
        async_reset();
        rdy = 1'b1;
        send(8'h44);
        chk("s6_sop_after", sop, 1'b1);
        idle(4);
        flush();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            pv  = ($urandom_range(0, 3) != 0);
            pix = 8'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 199) == 0);
            step(ok);
            if ($urandom_range(0, 599) == 0) begin
                clr = 1'b0;
                async_reset();
            end
        end
        clr = 1'b0;
        chk("frames_seen", frames > 10, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
